// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch channel: the fetch stage issues req/addr, memory answers with rdy/rdata.
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic [31:0] rdata;

  modport master (output req, addr, input rdy, rdata);
  modport slave  (input req, addr, output rdy, rdata);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, fetches over a req/rdy handshake into the IR,
// and computes the next PC (sequential, branch, jump, jr).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        npc_sel,
  input  logic              branch_taken,
  input  logic [31:0]       imm32,
  input  logic [31:0]       jr_target,
  ifu_fetch_if.master       imem,
  output logic [31:0]       instr,
  output logic [15:0]       imm16,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              addr_err
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_e;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] npc;
  logic        req;

  assign pc_plus4 = pc_q + 32'd4;

  // All arithmetic is modulo 2^32; negative branch offsets and pc wrap naturally.
  always_comb begin
    unique case (npc_sel)
      NPC_SEQ:  npc = pc_plus4;
      NPC_BR:   npc = branch_taken ? (pc_plus4 + (imm32 << 2)) : pc_plus4;
      NPC_JUMP: npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      NPC_JR:   npc = jr_target;
      default:  npc = pc_plus4;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    req     = 1'b0;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem.rdy) begin
          instr_d = imem.rdata;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          valid_d = 1'b0;
          // A misaligned jr target is fatal: keep pc pointing at the offending jr.
          if (npc_sel == NPC_JR && jr_target[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = npc;
            state_d = FETCH;
          end
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem.req    = req;
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign imm16       = instr_q[15:0];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign addr_err    = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch: one table row per clock cycle.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [31:0] imm32;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  ifu_fetch_if imem_bus ();

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm32        (imm32),
    .jr_target    (jr_target),
    .imem         (imem_bus),
    .instr        (instr),
    .imm16        (imm16),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        taken;
    logic [31:0] imm;
    logic [31:0] jr;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic [1:0] sel, input logic tk,
                     input logic [31:0] imm, input logic [31:0] jr, input logic rdy,
                     input logic [31:0] rdata, input logic e_req, input logic [31:0] e_pc,
                     input logic e_valid, input logic [31:0] e_instr, input logic e_err);
    vec_t v;
    v.rst = r; v.stall = st; v.sel = sel; v.taken = tk; v.imm = imm; v.jr = jr;
    v.rdy = rdy; v.rdata = rdata; v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_pc,
                               input logic e_valid, input logic [31:0] e_instr, input logic e_err);
    check({tag, " req"},      {31'd0, imem_bus.req}, {31'd0, e_req});
    check({tag, " addr"},     imem_bus.addr, e_pc);
    check({tag, " pc"},       pc, e_pc);
    check({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    check({tag, " valid"},    {31'd0, instr_valid}, {31'd0, e_valid});
    check({tag, " instr"},    instr, e_instr);
    check({tag, " imm16"},    {16'd0, imm16}, {16'd0, e_instr[15:0]});
    check({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
  endtask

  initial begin
    // rst stall sel tk imm jr rdy rdata | req pc valid instr err
    // Sequential fetch, rdy always high.
    add(0,0,2'b00,0,0,0,1,32'h1111_0001, 0,32'h3000,0,32'h0,0);           // 0 BOOT
    add(0,0,2'b00,0,0,0,1,32'h1111_0001, 1,32'h3000,0,32'h0,0);           // 1 FETCH
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h3000,1,32'h1111_0001,0);   // 2 EXEC
    add(0,0,2'b00,0,0,0,1,32'h2222_0002, 1,32'h3004,0,32'h1111_0001,0);   // 3 FETCH
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h3004,1,32'h2222_0002,0);   // 4 EXEC
    add(0,0,2'b00,0,0,0,1,32'h3333_0003, 1,32'h3008,0,32'h2222_0002,0);   // 5 FETCH
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h3008,1,32'h3333_0003,0);   // 6 EXEC
    add(0,0,2'b00,0,0,0,1,32'h4444_0004, 1,32'h300C,0,32'h3333_0003,0);   // 7 FETCH
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h300C,1,32'h4444_0004,0);   // 8 EXEC
    // Memory not ready for 5 cycles; stall has no effect in FETCH.
    for (int i = 0; i < 5; i++)
      add(0,1,2'b00,0,0,0,0,32'hBAD0_0000 + i, 1,32'h3010,0,32'h4444_0004,0);
    add(0,0,2'b00,0,0,0,1,32'h5555_0005, 1,32'h3010,0,32'h4444_0004,0);   // 14 FETCH
    // Stall 3 cycles with a taken branch pending, then release: branch still taken.
    for (int i = 0; i < 3; i++)
      add(0,1,2'b01,1,32'hFFFF_FFFC,0,1,32'hDEAD_BEEF, 0,32'h3010,1,32'h5555_0005,0);
    add(0,0,2'b01,1,32'hFFFF_FFFC,0,1,32'hDEAD_BEEF, 0,32'h3010,1,32'h5555_0005,0);
    add(0,0,2'b00,0,0,0,1,32'h6666_0006, 1,32'h3004,0,32'h5555_0005,0);   // 19 FETCH
    add(0,0,2'b01,0,32'hFFFF_FFFC,0,1,32'hDEAD_BEEF, 0,32'h3004,1,32'h6666_0006,0); // not taken
    add(0,0,2'b00,0,0,0,1,32'h0800_0C10, 1,32'h3008,0,32'h6666_0006,0);   // 21 FETCH j
    add(0,0,2'b10,0,0,0,1,32'hDEAD_BEEF, 0,32'h3008,1,32'h0800_0C10,0);   // 22 EXEC j
    add(0,0,2'b00,0,0,0,1,32'h7777_0007, 1,32'h3040,0,32'h0800_0C10,0);   // 23 FETCH
    add(0,0,2'b11,0,0,32'h3100,1,32'hDEAD_BEEF, 0,32'h3040,1,32'h7777_0007,0); // jr 3100
    add(0,0,2'b00,0,0,0,1,32'h8888_0008, 1,32'h3100,0,32'h7777_0007,0);   // 25 FETCH
    add(0,0,2'b11,0,0,32'hFFFF_FFFC,1,32'hDEAD_BEEF, 0,32'h3100,1,32'h8888_0008,0);
    add(0,0,2'b00,0,0,0,1,32'h9999_0009, 1,32'hFFFF_FFFC,0,32'h8888_0008,0);
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'hFFFF_FFFC,1,32'h9999_0009,0); // wraps to 0
    add(0,0,2'b00,0,0,0,1,32'hAAAA_000A, 1,32'h0,0,32'h9999_0009,0);      // 29 FETCH
    add(0,0,2'b11,0,0,32'h3102,1,32'hDEAD_BEEF, 0,32'h0,1,32'hAAAA_000A,0); // misaligned jr
    // HALT: frozen regardless of inputs.
    for (int i = 0; i < 3; i++)
      add(0,0,2'b00,1,32'h4,32'h3000,1,32'hDEAD_BEEF, 0,32'h0,0,32'hAAAA_000A,1);
    add(1,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h0,0,32'hAAAA_000A,1);      // 34 rst in HALT
    add(0,0,2'b00,0,0,0,1,32'hDEAD_BEEF, 0,32'h3000,0,32'h0,0);           // 35 BOOT
    add(1,0,2'b00,0,0,0,1,32'hCCCC_000C, 1,32'h3000,0,32'h0,0);           // 36 rst mid-fetch
    add(0,0,2'b00,0,0,0,1,32'hCCCC_000C, 0,32'h3000,0,32'h0,0);           // 37 BOOT
    add(0,0,2'b00,0,0,0,0,32'hCCCC_000C, 1,32'h3000,0,32'h0,0);           // 38 FETCH

    rst = 1'b1; stall = 1'b0; npc_sel = 2'b00; branch_taken = 1'b0;
    imm32 = '0; jr_target = '0; imem_bus.rdy = 1'b1; imem_bus.rdata = 32'hFEED_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h3000, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      stall          = vecs[i].stall;
      npc_sel        = vecs[i].sel;
      branch_taken   = vecs[i].taken;
      imm32          = vecs[i].imm;
      jr_target      = vecs[i].jr;
      imem_bus.rdy   = vecs[i].rdy;
      imem_bus.rdata = vecs[i].rdata;
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_err);
      @(negedge clk);
    end

    // Misaligned jr from a non-zero pc: HALT holds pc at the jr and keeps req low for a while.
    imem_bus.rdy = 1'b1; imem_bus.rdata = 32'h1234_5678; npc_sel = 2'b11;
    jr_target = 32'h0000_3101; rst = 1'b0;
    @(negedge clk);                 // FETCH -> EXEC
    @(negedge clk);                 // EXEC jr -> HALT
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("halt%0d req", i), {31'd0, imem_bus.req}, 32'd0);
      check($sformatf("halt%0d pc", i), pc, 32'h3000);
      check($sformatf("halt%0d err", i), {31'd0, addr_err}, 32'd1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
